pattern_hit_window_counter: RTL



---
 rtl/pattern_hit_window_counter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pattern_hit_window_counter.sv
// Counts detector hits over a programmable window of clock cycles and publishes
// the saturating count, a threshold alarm and an overflow flag once per window.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start with a non-zero window length
// ST_RUN  | counting hits, remaining holds the cycles still to sample
// ST_DONE | one-cycle result strobe, published outputs just loaded
module pattern_hit_window_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] hit_count,
  output logic             alarm,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state, state_nxt;
  logic [WIN_W-1:0] remaining, remaining_nxt;
  logic [CNT_W-1:0] run_cnt, run_cnt_nxt;
  logic [CNT_W-1:0] thr_q, thr_nxt;
  logic             run_ovf, run_ovf_nxt;
  logic [CNT_W-1:0] hit_count_nxt;
  logic             alarm_nxt, overflow_nxt;
  logic             busy_nxt, done_nxt;

  logic             sat_hit;
  logic [CNT_W-1:0] cnt_inc;

  // The last RUN cycle's hit must reach the published result on the same
  // edge, so the saturating increment is formed combinationally.
  always_comb begin
    sat_hit = hit && (run_cnt == CNT_MAX);
    cnt_inc = (hit && !sat_hit) ? run_cnt + CNT_ONE : run_cnt;
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    run_cnt_nxt   = run_cnt;
    thr_nxt       = thr_q;
    run_ovf_nxt   = run_ovf;
    hit_count_nxt = hit_count;
    alarm_nxt     = alarm;
    overflow_nxt  = overflow;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start && (win_len != '0)) begin
          state_nxt     = ST_RUN;
          remaining_nxt = win_len;
          thr_nxt       = threshold;
          run_cnt_nxt   = '0;
          run_ovf_nxt   = 1'b0;
          busy_nxt      = 1'b1;
        end
      end

      ST_RUN: begin
        busy_nxt      = 1'b1;
        run_cnt_nxt   = cnt_inc;
        run_ovf_nxt   = run_ovf | sat_hit;
        remaining_nxt = remaining - WIN_ONE;
        // Leaving at 1 keeps remaining from ever wrapping.
        if (remaining == WIN_ONE) begin
          state_nxt     = ST_DONE;
          hit_count_nxt = cnt_inc;
          alarm_nxt     = (cnt_inc >= thr_q);
          overflow_nxt  = run_ovf | sat_hit;
          done_nxt      = 1'b1;
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      run_cnt   <= '0;
      thr_q     <= '0;
      run_ovf   <= 1'b0;
      hit_count <= '0;
      alarm     <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      run_cnt   <= run_cnt_nxt;
      thr_q     <= thr_nxt;
      run_ovf   <= run_ovf_nxt;
      hit_count <= hit_count_nxt;
      alarm     <= alarm_nxt;
      overflow  <= overflow_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule
